// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: one shift-add or restoring-subtract step per cycle,
// followed by a single sign-correction cycle. Valid/ready handshake on both sides.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      ALUOp,
    input  logic [XLEN-1:0] OperandA,
    input  logic [XLEN-1:0] OperandB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            busy
);

    localparam logic [4:0] OpMul    = 5'd16;
    localparam logic [4:0] OpMulh   = 5'd17;
    localparam logic [4:0] OpMulhsu = 5'd18;
    localparam logic [4:0] OpMulhu  = 5'd19;
    localparam logic [4:0] OpDiv    = 5'd20;
    localparam logic [4:0] OpDivu   = 5'd21;
    localparam logic [4:0] OpRem    = 5'd22;
    localparam logic [4:0] OpRemu   = 5'd23;

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [4:0]          op_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opb_q;
    logic                neg_q;
    logic                rem_neg_q;

    // Input-side decode
    logic            is_m, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic            special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_m     = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (ALUOp)
            OpMul, OpMulhu, OpDivu, OpRemu: is_m = 1'b1;
            OpMulh, OpDiv, OpRem: begin
                is_m     = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OpMulhsu: begin
                is_m     = 1'b1;
                a_signed = 1'b1;
            end
            default: is_m = 1'b0;
        endcase
        is_div = (ALUOp == OpDiv) || (ALUOp == OpDivu) || (ALUOp == OpRem) || (ALUOp == OpRemu);
        is_rem = (ALUOp == OpRem) || (ALUOp == OpRemu);
        a_neg  = a_signed & OperandA[XLEN-1];
        b_neg  = b_signed & OperandB[XLEN-1];
        a_mag  = a_neg ? -OperandA : OperandA;
        b_mag  = b_neg ? -OperandB : OperandB;

        special     = 1'b0;
        special_res = '0;
        if (is_div && (OperandB == '0)) begin
            special     = 1'b1;
            special_res = is_rem ? OperandA : '1;
        end else if (((ALUOp == OpDiv) || (ALUOp == OpRem)) && (OperandA == MinNeg)
                     && (OperandB == '1)) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : MinNeg;
        end
    end

    // Iteration step and final sign correction
    logic              op_is_div;
    logic [XLEN:0]     mul_sum, div_tmp, div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        op_is_div = (op_q == OpDiv) || (op_q == OpDivu) || (op_q == OpRem) || (op_q == OpRemu);

        // Multiply: hi half accumulates, lo half holds the multiplier shifting out LSB-first
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: hi half is the partial remainder, lo half shifts dividend out / quotient in
        div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = div_tmp >= {1'b0, opb_q};
        div_sub  = div_tmp - {1'b0, opb_q};
        div_next = {(div_ge ? div_sub[XLEN-1:0] : div_tmp[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            OpMul:                    fix_res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:            fix_res = quo;
            default:                  fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            out_valid <= 1'b0;
            Result    <= '0;
        end else if (flush) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && is_m) begin
                        op_q      <= ALUOp;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        cnt_q     <= '0;
                        if (special) begin
                            Result    <= special_res;
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            opb_q   <= is_div ? b_mag : a_mag;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= op_is_div ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    Result    <= fix_res;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
            endcase
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

endmodule
